// File: rtl/mem_access_unit.sv
// Pipeline MEM stage: serializes loads/stores onto a req/ack data bus and
// drives the MEM/WB register, with misalignment and bus-timeout detection.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_EX_MEM,
  input  logic [31:0] rf_data2_EX_MEM,
  input  logic [31:0] instr_EX_MEM,
  input  logic        mem_en_EX_MEM,
  input  logic        mem_rd_wr_EX_MEM,
  input  logic [4:0]  rd_EX_MEM,
  input  logic        reg_write_EX_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic [31:0] wb_data_MEM_WB,
  output logic [4:0]  rd_MEM_WB,
  output logic        reg_write_MEM_WB,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state, next_state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    func3, f3_q;
  logic [1:0]    off_q;
  logic [4:0]    rd_q;
  logic          rw_q;
  logic          illegal, start, timeout_hit;
  logic [31:0]   wdata_n, load_data, rdata_shift;
  logic [3:0]    be_n;
  logic [15:0]   rhalf;
  logic [7:0]    rbyte;
  logic          unused_instr_bits;

  assign func3             = instr_EX_MEM[14:12];
  assign unused_instr_bits = ^{instr_EX_MEM[31:15], instr_EX_MEM[11:0]};
  assign start             = mem_en_EX_MEM & ~illegal;
  // The counter holds the index of the current WAIT cycle, so the abort lands
  // in the TIMEOUT-th WAIT cycle.
  assign timeout_hit       = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    illegal = 1'b0;
    case (func3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = alu_result_EX_MEM[0];
      3'b010:  illegal = |alu_result_EX_MEM[1:0];
      3'b100:  illegal = mem_rd_wr_EX_MEM;
      3'b101:  illegal = mem_rd_wr_EX_MEM | alu_result_EX_MEM[0];
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    wdata_n = '0;
    be_n    = '1;
    if (mem_rd_wr_EX_MEM) begin
      case (func3[1:0])
        2'b00: begin
          wdata_n = {4{rf_data2_EX_MEM[7:0]}};
          be_n    = 4'b0001 << alu_result_EX_MEM[1:0];
        end
        2'b01: begin
          wdata_n = {2{rf_data2_EX_MEM[15:0]}};
          be_n    = alu_result_EX_MEM[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_n = rf_data2_EX_MEM;
          be_n    = '1;
        end
      endcase
    end
  end

  always_comb begin
    rdata_shift = dmem_rdata >> {off_q, 3'b000};
    rbyte       = rdata_shift[7:0];
    rhalf       = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_data = {24'h0, rbyte};
      3'b101:  load_data = {16'h0, rhalf};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    stall_mem  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        next_state = S_WAIT;
        stall_mem  = 1'b1;
      end
      S_WAIT: if (dmem_ack || timeout_hit) next_state = S_IDLE;
              else                         stall_mem  = 1'b1;
    endcase
    if (rst) stall_mem = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= '0;
      dmem_wdata       <= '0;
      dmem_be          <= '0;
      wb_data_MEM_WB   <= '0;
      rd_MEM_WB        <= '0;
      reg_write_MEM_WB <= 1'b0;
      misalign_err     <= 1'b0;
      bus_err          <= 1'b0;
      wait_cnt         <= '0;
      f3_q             <= '0;
      off_q            <= '0;
      rd_q             <= '0;
      rw_q             <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!mem_en_EX_MEM) begin
            wb_data_MEM_WB   <= alu_result_EX_MEM;
            rd_MEM_WB        <= rd_EX_MEM;
            reg_write_MEM_WB <= reg_write_EX_MEM;
          end else if (illegal) begin
            wb_data_MEM_WB   <= '0;
            rd_MEM_WB        <= rd_EX_MEM;
            reg_write_MEM_WB <= 1'b0;
            misalign_err     <= 1'b1;
          end else begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_rd_wr_EX_MEM;
            dmem_addr  <= {alu_result_EX_MEM[31:2], 2'b00};
            dmem_wdata <= wdata_n;
            dmem_be    <= be_n;
            f3_q       <= func3;
            off_q      <= alu_result_EX_MEM[1:0];
            rd_q       <= rd_EX_MEM;
            rw_q       <= reg_write_EX_MEM;
            wait_cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            rd_MEM_WB <= rd_q;
            if (dmem_we) begin
              wb_data_MEM_WB   <= '0;
              reg_write_MEM_WB <= 1'b0;
            end else begin
              wb_data_MEM_WB   <= load_data;
              reg_write_MEM_WB <= rw_q;
            end
          end else if (timeout_hit) begin
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            wb_data_MEM_WB   <= '0;
            rd_MEM_WB        <= rd_q;
            reg_write_MEM_WB <= 1'b0;
            bus_err          <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: byte-level memory reference
// model, bus slave with random ack latency, decoupled retire/request monitor.
module tb_mem_access_unit;

  localparam int TMO = 15;

  logic        clk, rst;
  logic [31:0] alu_result, rf_data2, instr;
  logic        mem_en, mem_rd_wr, reg_write;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_mem, reg_write_wb, misalign_err, bus_err;
  logic [31:0] wb_data;
  logic [4:0]  rd_wb;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .alu_result_EX_MEM(alu_result), .rf_data2_EX_MEM(rf_data2),
    .instr_EX_MEM(instr), .mem_en_EX_MEM(mem_en),
    .mem_rd_wr_EX_MEM(mem_rd_wr), .rd_EX_MEM(rd),
    .reg_write_EX_MEM(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_mem(stall_mem), .wb_data_MEM_WB(wb_data), .rd_MEM_WB(rd_wb),
    .reg_write_MEM_WB(reg_write_wb),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        berr;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] bus_mem [0:255];
  int   total = 0;
  int   bad = 0;
  int   cur_lat = 1;
  logic driving = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic poke(input int unsigned a, input logic [31:0] w);
    bus_mem[a/4] = w;
    for (int unsigned i = 0; i < 4; i++) ref_mem[(a & ~3) + i] = w[8*i +: 8];
  endtask

  function automatic int unsigned acc_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic is_legal(input logic wr, input logic [2:0] f3, input int unsigned a);
    int unsigned sz = acc_size(f3);
    if (sz == 0) return 1'b0;
    if (wr && (f3 == 3'd4 || f3 == 3'd5)) return 1'b0;
    return (a % sz) == 0;
  endfunction

  // Slave: counts request cycles and acks in the cur_lat-th one (0 = never).
  initial begin
    int wcnt = 0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (dmem_req) begin
        wcnt++;
        if (cur_lat != 0 && wcnt == cur_lat) begin
          dmem_ack = 1'b1;
          if (dmem_we) begin
            for (int i = 0; i < 4; i++)
              if (dmem_be[i]) bus_mem[dmem_addr[9:2]][8*i +: 8] = dmem_wdata[8*i +: 8];
            dmem_rdata = $urandom;
          end else begin
            dmem_rdata = bus_mem[dmem_addr[9:2]];
          end
        end else begin
          dmem_ack = 1'b0;
          dmem_rdata = $urandom;
        end
      end else begin
        wcnt = 0;
        dmem_ack = ($urandom_range(0, 7) == 0);
        dmem_rdata = $urandom;
      end
    end
  end

  // Monitor: an instruction retires in every unstalled cycle it is presented.
  initial begin
    logic retire;
    logic prev_req = 1'b0;
    wb_t  e;
    req_t r;
    r = '{addr: '0, we: 1'b0, be: '0, wdata: '0};
    forever begin
      @(negedge clk);
      retire = driving && !stall_mem && !rst;
      @(posedge clk); #1;
      if (retire) begin
        if (wb_q.size() == 0) begin
          chk("unexpected_retire", 32'd1, 32'd0);
        end else begin
          e = wb_q.pop_front();
          chk("wb_reg_write", {31'd0, reg_write_wb}, {31'd0, e.rw});
          if (e.rw) begin
            chk("wb_data", wb_data, e.data);
            chk("wb_rd", {27'd0, rd_wb}, {27'd0, e.rd});
          end
          chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
          chk("bus_err", {31'd0, bus_err}, {31'd0, e.berr});
        end
      end else begin
        chk("misalign_idle", {31'd0, misalign_err}, 32'd0);
        chk("bus_err_idle", {31'd0, bus_err}, 32'd0);
      end
      if (dmem_req) begin
        if (!prev_req) begin
          if (req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
          else r = req_q.pop_front();
        end
        chk("req_addr", dmem_addr, r.addr);
        chk("req_we", {31'd0, dmem_we}, {31'd0, r.we});
        chk("req_be", {28'd0, dmem_be}, {28'd0, r.be});
        if (r.we) chk("req_wdata", dmem_wdata, r.wdata);
      end
      prev_req = dmem_req;
    end
  end

  task automatic issue(input logic en, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] data,
                       input logic [4:0] rdi, input logic rw, input int lat);
    wb_t  e;
    req_t r;
    int   stalls = 0;
    int   exp_stalls = 0;
    logic [31:0] iw, v;
    int unsigned ai = a[9:0];
    @(posedge clk); #2;
    iw = $urandom;
    iw[14:12] = f3;
    alu_result = a; rf_data2 = data; instr = iw; mem_en = en;
    mem_rd_wr = wr; rd = rdi; reg_write = rw; cur_lat = lat;
    driving = 1'b1;
    e = '{data: a, rd: rdi, rw: rw, mis: 1'b0, berr: 1'b0};
    if (en) begin
      if (!is_legal(wr, f3, ai)) begin
        e.rw = 1'b0; e.mis = 1'b1;
      end else begin
        exp_stalls = (lat == 0) ? TMO : lat;
        r.addr = a & ~32'd3;
        r.we = wr;
        r.be = wr ? 4'b0 : 4'hF;
        r.wdata = '0;
        if (wr) begin
          for (int unsigned i = 0; i < acc_size(f3); i++) begin
            r.be[(ai + i) % 4] = 1'b1;
            r.wdata[8*((ai + i) % 4) +: 8] = data[8*i +: 8];
          end
          if (f3 == 3'd0) r.wdata = {4{data[7:0]}};
          if (f3 == 3'd1) r.wdata = {2{data[15:0]}};
          if (lat != 0)
            for (int unsigned i = 0; i < acc_size(f3); i++) ref_mem[ai + i] = data[8*i +: 8];
          e.rw = 1'b0;
        end else if (lat == 0) begin
          e.rw = 1'b0;
        end else begin
          v = '0;
          for (int unsigned i = 0; i < acc_size(f3); i++) v[8*i +: 8] = ref_mem[ai + i];
          if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
          if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
          e.data = v;
        end
        if (lat == 0) e.berr = 1'b1;
        req_q.push_back(r);
      end
    end
    wb_q.push_back(e);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall_mem) break;
      stalls++;
    end
    chk("stall_cycles", stalls, exp_stalls);
  endtask

  initial begin
    logic [2:0] f3tab [12];
    f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7, 3'd2};
    for (int unsigned w = 0; w < 256; w++) poke(w * 4, (w * 32'h9E3779B1) ^ 32'h5A5A0F0F);
    rst = 1'b1; alu_result = '0; rf_data2 = '0; instr = '0;
    mem_en = 1'b0; mem_rd_wr = 1'b0; rd = '0; reg_write = 1'b0;
    #3;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_stall", {31'd0, stall_mem}, 32'd0);
    chk("rst_wb", {wb_data[31:6], rd_wb, reg_write_wb}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    poke(32'h100, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 5'd5, 1'b1, 1);        // LW
    poke(32'h100, 32'h80112233);
    issue(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 5'd6, 1'b1, 1);        // LB
    issue(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 5'd7, 1'b1, 2);        // LBU
    issue(1'b1, 1'b1, 3'd1, 32'h202, 32'h0000ABCD, 5'd8, 1'b1, 1); // SH
    issue(1'b1, 1'b0, 3'd1, 32'h202, 32'h0, 5'd9, 1'b1, 3);        // LH of stored half
    issue(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 5'd10, 1'b1, 1);       // misaligned LW
    issue(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 5'd11, 1'b1, 0);       // timeout
    issue(1'b0, 1'b0, 3'd0, 32'h12345678, 32'h0, 5'd12, 1'b1, 1);  // ADD

    // Reset two cycles into WAIT discards the access.
    @(posedge clk); #2;
    driving = 1'b0;
    alu_result = 32'h40; instr = 32'h0000_2000; mem_en = 1'b1; mem_rd_wr = 1'b0;
    rd = 5'd3; reg_write = 1'b1; cur_lat = 0;
    req_q.push_back('{addr: 32'h40, we: 1'b0, be: 4'hF, wdata: '0});
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_wait_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_wait_stall", {31'd0, stall_mem}, 32'd0);
    chk("rst_wait_wb", {wb_data[31:6], rd_wb, reg_write_wb}, 32'd0);
    mem_en = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    issue(1'b0, 1'b0, 3'd0, 32'hCAFE0001, 32'h0, 5'd14, 1'b1, 1);  // ADD after reset

    for (int n = 0; n < 300; n++) begin
      issue($urandom_range(0, 9) > 2, $urandom_range(0, 1), f3tab[$urandom_range(0, 11)],
            (($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023))),
            $urandom, 5'($urandom), 1'($urandom), $urandom_range(1, 4));
    end
    issue(1'b1, 1'b1, 3'd0, 32'h3FF, 32'h000000A5, 5'd1, 1'b1, 1);
    issue(1'b1, 1'b0, 3'd5, 32'h3FE, 32'h0, 5'd2, 1'b1, 2);

    @(posedge clk); #2;
    driving = 1'b0;
    mem_en = 1'b0;
    repeat (3) @(posedge clk);
    chk("wb_queue_drained", wb_q.size(), 32'd0);
    chk("req_queue_drained", req_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
